// File: rtl/midi_pkg.sv
// Shared MIDI definitions: event layout, status nibbles, FSM states and status-byte builder.
package midi_pkg;

    localparam logic [2:0] NOTE_OFF        = 3'd0;
    localparam logic [2:0] NOTE_ON         = 3'd1;
    localparam logic [3:0] STATUS_NOTE_OFF = 4'h8;
    localparam logic [3:0] STATUS_NOTE_ON  = 4'h9;
    localparam int         EVT_W           = 15;

    typedef struct packed {
        logic       note_on;
        logic [6:0] note;
        logic [6:0] velocity;
    } midi_evt_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STATUS = 2'd1,
        ST_DATA1  = 2'd2,
        ST_DATA2  = 2'd3
    } midi_state_t;

    function automatic logic [7:0] status_byte(input logic note_on, input logic [3:0] ch);
        logic [2:0] kind;
        kind = note_on ? NOTE_ON : NOTE_OFF;
        return {((kind == NOTE_ON) ? STATUS_NOTE_ON : STATUS_NOTE_OFF), ch};
    endfunction

endpackage

// File: rtl/midi_evt_fifo.sv
// Synchronous event FIFO, power-of-two depth; dout shows the head entry whenever empty is low.
// Pushes into a full FIFO and pops from an empty one are ignored.
module midi_evt_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout  = mem[rptr_q];
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/midi_msg_tx.sv
// Buffers note events and serializes each as status/note/velocity bytes; first byte 2 cycles after accept, stalls on byte_ready low.
// Optional `MIDI_RUNNING_STATUS_EN omits a status byte equal to the last one sent.
module midi_msg_tx
    import midi_pkg::*;
#(
    parameter int MY_MIDI_CH_ADDR = 0,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       evt_valid,
    output logic       evt_ready,
    input  logic       evt_note_on,
    input  logic [6:0] evt_note,
    input  logic [6:0] evt_velocity,
    output logic       byte_valid,
    output logic [7:0] byte_value,
    input  logic       byte_ready,
    output logic       busy
);

    localparam logic [3:0] CH = 4'(MY_MIDI_CH_ADDR);

    midi_evt_t   evt_in;
    midi_evt_t   fifo_dout;
    midi_evt_t   hold_q;
    midi_state_t state_q;
    midi_state_t state_d;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic        ready_en_q;
    logic        skip_status;

    assign evt_in = '{note_on: evt_note_on, note: evt_note, velocity: evt_velocity};

    midi_evt_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (evt_valid && evt_ready),
        .din   (evt_in),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Held low through reset and released by the first edge afterwards; never sees byte_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ready_en_q <= 1'b0;
        else     ready_en_q <= 1'b1;
    end

    assign evt_ready = ready_en_q && !fifo_full;
    assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
    assign busy      = !fifo_empty || (state_q != ST_IDLE);

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] last_status_q;
    logic       last_vld_q;
    logic [7:0] idle_cnt_q;

    // Stored status expires after 256 consecutive empty cycles so receivers can resync.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_status_q <= 8'h00;
            last_vld_q    <= 1'b0;
            idle_cnt_q    <= 8'h00;
        end else begin
            if (!fifo_empty)              idle_cnt_q <= 8'h00;
            else if (idle_cnt_q != 8'hFF) idle_cnt_q <= idle_cnt_q + 8'd1;

            if (state_q == ST_STATUS && byte_ready) begin
                last_status_q <= byte_value;
                last_vld_q    <= 1'b1;
            end else if (fifo_empty && idle_cnt_q == 8'hFF) begin
                last_vld_q    <= 1'b0;
            end
        end
    end

    assign skip_status = last_vld_q && (last_status_q == status_byte(fifo_dout.note_on, CH));
`else
    assign skip_status = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           hold_q <= '0;
        else if (fifo_pop) hold_q <= fifo_dout;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!fifo_empty) state_d = skip_status ? ST_DATA1 : ST_STATUS;
            ST_STATUS: if (byte_ready)  state_d = ST_DATA1;
            ST_DATA1:  if (byte_ready)  state_d = ST_DATA2;
            ST_DATA2:  if (byte_ready)  state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_valid = 1'b0;
        byte_value = 8'h00;
        case (state_q)
            ST_STATUS: begin
                byte_valid = 1'b1;
                byte_value = status_byte(hold_q.note_on, CH);
            end
            ST_DATA1: begin
                byte_valid = 1'b1;
                byte_value = {1'b0, hold_q.note};
            end
            ST_DATA2: begin
                byte_valid = 1'b1;
                byte_value = {1'b0, hold_q.velocity};
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_midi_msg_tx.sv
// Randomized bench for midi_msg_tx: a byte-queue reference model fed by accepted events, checked at every byte handshake.
module tb_midi_msg_tx;

    localparam int CH = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       evt_valid;
    logic       evt_ready;
    logic       evt_note_on;
    logic [6:0] evt_note;
    logic [6:0] evt_velocity;
    logic       byte_valid;
    logic [7:0] byte_value;
    logic       byte_ready;
    logic       busy;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         rdy_mode = 1;
    logic [7:0] exp_q[$];
    logic [7:0] obs[$];
    int         obs_cyc[$];
    logic       stall_vld = 1'b0;
    logic [7:0] stall_val = 8'h00;
    logic       lat_arm = 1'b0;
    int         lat_start = 0;

    midi_msg_tx #(
        .MY_MIDI_CH_ADDR (CH),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_note_on  (evt_note_on),
        .evt_note     (evt_note),
        .evt_velocity (evt_velocity),
        .byte_valid   (byte_valid),
        .byte_value   (byte_value),
        .byte_ready   (byte_ready),
        .busy         (busy)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs_at(input int i);
        return (i < obs.size()) ? {24'h0, obs[i]} : 32'hBAD;
    endfunction

    function automatic int cyc_at(input int i);
        return (i < obs_cyc.size()) ? obs_cyc[i] : -1000;
    endfunction

    // byte_ready: 0 = stalled, 1 = always ready, otherwise a fair coin each cycle
    initial begin
        byte_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       byte_ready = 1'b0;
                1:       byte_ready = 1'b1;
                default: byte_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor and reference model: each accepted event expands into its three MIDI bytes.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            stall_vld = 1'b0;
            lat_arm   = 1'b0;
        end else begin
            if (stall_vld) begin
                chk("stall_valid_held", byte_valid, 1);
                chk("stall_value_held", byte_value, stall_val);
            end
            if (evt_valid && evt_ready) begin
                exp_q.push_back((evt_note_on ? 8'h90 : 8'h80) | 8'(CH));
                exp_q.push_back({1'b0, evt_note});
                exp_q.push_back({1'b0, evt_velocity});
                if (!busy) begin
                    lat_arm   = 1'b1;
                    lat_start = cyc;
                end
            end
            if (byte_valid && lat_arm) begin
                chk("first_byte_latency", cyc - lat_start, 2);
                lat_arm = 1'b0;
            end
            if (byte_valid && byte_ready) begin
                if (exp_q.size() == 0) chk("spurious_byte", {24'h0, byte_value}, 32'hBAD);
                else                   chk("stream_byte", byte_value, exp_q.pop_front());
                obs.push_back(byte_value);
                obs_cyc.push_back(cyc);
            end
            stall_vld = byte_valid && !byte_ready;
            stall_val = byte_value;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_evt(input logic on, input logic [6:0] n, input logic [6:0] v);
        int  budget = 2000;
        bit  done = 1'b0;
        evt_valid    = 1'b1;
        evt_note_on  = on;
        evt_note     = n;
        evt_velocity = v;
        while (!done && budget > 0) begin
            @(negedge clk);
            done = evt_ready;
            @(posedge clk); #1;
            budget--;
        end
        evt_valid = 1'b0;
        if (!done) chk("evt_accept_timeout", 0, 1);
    endtask

    task automatic wait_drain(input string tag);
        int budget = 3000;
        while ((busy || exp_q.size() != 0) && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        chk(tag, (exp_q.size() == 0 && !busy), 1);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int n1;
        rst          = 1'b1;
        evt_valid    = 1'b0;
        evt_note_on  = 1'b0;
        evt_note     = 7'd0;
        evt_velocity = 7'd0;

        #3;
        chk("rst_evt_ready", evt_ready, 0);
        chk("rst_byte_valid", byte_valid, 0);
        chk("rst_byte_value", byte_value, 8'h00);
        chk("rst_busy", busy, 0);
        cycles(2);
        chk("rst_evt_ready_held", evt_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("evt_ready_before_edge", evt_ready, 0);
        @(posedge clk); #1;
        chk("evt_ready_after_release", evt_ready, 1);

        // Single NOTE_ON, then NOTE_OFF with zero velocity
        n0 = obs.size();
        send_evt(1'b1, 7'd60, 7'd100);
        wait_drain("drain_note_on");
        chk("note_on_count", obs.size() - n0, 3);
        chk("note_on_status", obs_at(n0), 8'h95);
        chk("note_on_note", obs_at(n0 + 1), 8'h3C);
        chk("note_on_vel", obs_at(n0 + 2), 8'h64);

        n0 = obs.size();
        send_evt(1'b0, 7'd60, 7'd0);
        wait_drain("drain_note_off");
        chk("note_off_status", obs_at(n0), 8'h85);
        chk("note_off_note", obs_at(n0 + 1), 8'h3C);
        chk("note_off_vel", obs_at(n0 + 2), 8'h00);

        // Back-to-back messages: 4 cycles per message, bytes on consecutive cycles
        n0 = obs.size();
        send_evt(1'b1, 7'd10, 7'd20);
        send_evt(1'b0, 7'd11, 7'd21);
        send_evt(1'b1, 7'd127, 7'd127);
        wait_drain("drain_b2b");
        chk("b2b_byte_spacing", cyc_at(n0 + 1) - cyc_at(n0), 1);
        chk("b2b_msg_spacing_1", cyc_at(n0 + 3) - cyc_at(n0), 4);
        chk("b2b_msg_spacing_2", cyc_at(n0 + 6) - cyc_at(n0 + 3), 4);
        chk("b2b_last_status", obs_at(n0 + 6), 8'h95);

        // Fill holding register plus FIFO under a stalled sink
        rdy_mode = 0;
        cycles(2);
        n0 = obs.size();
        send_evt(1'b1, 7'd1, 7'd2);
        send_evt(1'b0, 7'd3, 7'd4);
        send_evt(1'b1, 7'd5, 7'd6);
        send_evt(1'b0, 7'd7, 7'd8);
        send_evt(1'b1, 7'd9, 7'd10);
        chk("full_evt_ready", evt_ready, 0);
        chk("stall_status_valid", byte_valid, 1);
        chk("stall_status_value", byte_value, 8'h95);
        cycles(6);
        chk("full_evt_ready_still", evt_ready, 0);
        chk("busy_while_full", busy, 1);
        rdy_mode = 1;
        wait_drain("drain_full");
        chk("full_byte_count", obs.size() - n0, 15);
        chk("evt_ready_after_drain", evt_ready, 1);

        // Random events against a randomly stalling sink
        rdy_mode = 2;
        n0 = obs.size();
        for (int i = 0; i < 20; i++) begin
            send_evt(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)));
            cycles($urandom_range(0, 3));
        end
        wait_drain("drain_random");
        chk("random_byte_count", obs.size() - n0, 60);

        // Reset after the status byte, before the note byte
        rdy_mode = 1;
        cycles(2);
        n0 = obs.size();
        send_evt(1'b1, 7'd60, 7'd100);
        begin
            int budget = 100;
            while (obs.size() == n0 && budget > 0) begin
                @(posedge clk); #1;
                budget--;
            end
            chk("status_before_reset", obs_at(n0), 8'h95);
        end
        rst = 1'b1;
        #1;
        chk("midmsg_rst_byte_valid", byte_valid, 0);
        chk("midmsg_rst_byte_value", byte_value, 8'h00);
        chk("midmsg_rst_busy", busy, 0);
        chk("midmsg_rst_evt_ready", evt_ready, 0);
        cycles(2);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_evt_ready", evt_ready, 1);
        chk("post_rst_idle", busy, 0);
        n1 = obs.size();
        chk("no_resume_after_rst", n1 - n0, 1);
        send_evt(1'b1, 7'd64, 7'd90);
        wait_drain("drain_post_rst");
        chk("post_rst_count", obs.size() - n1, 3);
        chk("post_rst_status", obs_at(n1), 8'h95);
        chk("post_rst_note", obs_at(n1 + 1), 8'h40);
        chk("post_rst_vel", obs_at(n1 + 2), 8'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
